// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Round-robin write arbiter for the shared DATA_W-bit enabled data register.
//   Up to four requesters compete for a write. At most one is granted per cycle.
//   The winner's byte is loaded on the rising edge, and the winner becomes the
//   lowest priority for the next arbitration.
//
// Ports
//   clk    : system clock, rising-edge
//   reset  : asynchronous, active-high; clears all state and forces ack=0
//   en     : global arbitration enable
//   req    : request lines, req[i] from requester i
//   data   : packed write data, requester i at data[i*DATA_W +: DATA_W]
//   ack    : one-hot grant (combinational from req, en, reset and the pointer)
//   q      : shared register contents
//   owner  : index of the requester that last wrote q
//   valid  : q holds data written since reset
module reg_write_arbiter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   data,
  output logic [3:0]            ack,
  output logic [DATA_W-1:0]     q,
  output logic [1:0]            owner,
  output logic                  valid
);

  logic [1:0]        ptr;
  logic [1:0]        win;
  logic              any_win;
  logic [1:0]        idx;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        one_hot;

  // Scan ptr+1, ptr+2, ptr+3, ptr in that order. The first active request wins.
  // The 2-bit add wraps modulo 4, so k=4 lands back on ptr.
  always_comb begin
    win     = '0;
    any_win = 1'b0;
    idx     = '0;
    if (en && !reset) begin
      for (int unsigned k = 1; k <= 4; k++) begin
        idx = ptr + k[1:0];
        if (!any_win && req[idx]) begin
          any_win = 1'b1;
          win     = idx;
        end
      end
    end
  end

  always_comb begin
    one_hot = 4'b0001;
    ack     = any_win ? (one_hot << win) : '0;
  end

  always_comb begin
    wdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (win == i[1:0]) wdata = data[i*DATA_W +: DATA_W];
    end
  end

  // Enabled register: load on any grant, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      owner <= '0;
      valid <= 1'b0;
      ptr   <= 2'd3;
    end else if (any_win) begin
      q     <= wdata;
      owner <= win;
      valid <= 1'b1;
      ptr   <= win;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] q;
    logic [1:0]        owner;
    logic              valid;
  } st_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                en;
  logic [3:0]          req;
  logic [4*DATA_W-1:0] data;
  logic [3:0]          ack;
  logic [DATA_W-1:0]   q;
  logic [1:0]          owner;
  logic                valid;

  int checks   = 0;
  int failures = 0;

  st_t cur;
  st_t sb[$];

  reg_write_arbiter #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .req   (req),
    .data  (data),
    .ack   (ack),
    .q     (q),
    .owner (owner),
    .valid (valid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input st_t e);
    chk({tag, ".q"},     32'(q),     32'(e.q));
    chk({tag, ".owner"}, 32'(owner), 32'(e.owner));
    chk({tag, ".valid"}, 32'(valid), 32'(e.valid));
  endtask

  // One arbitration cycle, entered in the clock-low phase. The expected ack
  // comes from the test plan. The expected register state is derived from it
  // and queued, then popped and compared after the edge.
  task automatic cycle(input string tag, input logic [3:0] r, input logic e,
                       input logic [3:0] exp_ack);
    st_t nxt;
    st_t got;
    req = r;
    en  = e;
    #1;
    chk({tag, ".ack"}, 32'(ack), 32'(exp_ack));
    nxt = cur;
    for (int i = 0; i < 4; i++) begin
      if (exp_ack[i]) begin
        nxt.q     = data[i*DATA_W +: DATA_W];
        nxt.owner = 2'(i);
        nxt.valid = 1'b1;
      end
    end
    sb.push_back(nxt);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    cur = got;
    chk_state(tag, got);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    cur = '0;
    chk("rst.ack", 32'(ack), 32'd0);
    chk_state("rst", cur);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    req   = '0;
    data  = '0;
    cur   = '0;
    @(negedge clk);
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 3; i++) cycle("idle", 4'b0000, 1'b1, 4'b0000);

    // Single request, then hold.
    data[2*DATA_W +: DATA_W] = 8'hA5;
    cycle("single", 4'b0100, 1'b1, 4'b0100);
    cycle("hold",   4'b0000, 1'b1, 4'b0000);

    // All four from reset.
    data = {8'h43, 8'h32, 8'h21, 8'h10};
    do_reset();
    cycle("rr0", 4'b1111, 1'b1, 4'b0001);
    cycle("rr1", 4'b1111, 1'b1, 4'b0010);
    cycle("rr2", 4'b1111, 1'b1, 4'b0100);
    cycle("rr3", 4'b1111, 1'b1, 4'b1000);
    cycle("rr4", 4'b1111, 1'b1, 4'b0001);

    // Rotation fairness after owner=1.
    cycle("own1",  4'b1111, 1'b1, 4'b0010);
    cycle("fair0", 4'b0011, 1'b1, 4'b0001);
    cycle("fair1", 4'b0011, 1'b1, 4'b0010);

    // Enable low: nothing moves; rotation resumes at ptr+1 = 2.
    cycle("en0a", 4'b1111, 1'b0, 4'b0000);
    cycle("en0b", 4'b1111, 1'b0, 4'b0000);
    cycle("en1",  4'b1111, 1'b1, 4'b0100);

    // Back-to-back single requester with an unused line skipped.
    cycle("b2b0", 4'b1000, 1'b1, 4'b1000);
    cycle("b2b1", 4'b1000, 1'b1, 4'b1000);

    // Reset mid-operation with all requesting and q=0x43.
    chk("pre.q", 32'(q), 32'h43);
    req   = 4'b1111;
    en    = 1'b1;
    reset = 1'b1;
    #1;
    cur = '0;
    chk("midrst.ack", 32'(ack), 32'd0);
    chk_state("midrst", cur);
    @(posedge clk);
    #1;
    chk_state("rstedge", cur);
    @(negedge clk);
    reset = 1'b0;
    cycle("post0", 4'b1111, 1'b1, 4'b0001);
    cycle("post1", 4'b1111, 1'b1, 4'b0010);

    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter for the shared 8-bit enabled data register in the Proyecto 2 datapath. Up to four requesters compete to load a byte. The arbiter grants at most one requester per cycle, and loads that requester's byte into the shared register. It also records which requester wrote last and rotates priority so no requester starves.

## Interface
Parameters:
- DATA_W, 8, width of each requester's data and of the shared register

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- en  input  1  global arbitration enable; when 0 no grant is issued
- req  input  4  request lines, req[i] from requester i
- data  input  4*DATA_W  packed write data; requester i occupies data[i*DATA_W +: DATA_W]
- ack  output  4  one-hot grant, combinational from req, en and the priority pointer
- q  output  DATA_W  shared register contents
- owner  output  2  index of the requester that last wrote q
- valid  output  1  q holds data written since reset

## Operation
- Reset is asynchronous, active-high, on clock clk. It forces:
  - q=0, owner=0, valid=0
  - internal last-winner pointer ptr=3, so requester 0 holds highest priority first.
- Priority order each cycle: ptr+1, ptr+2, ptr+3, ptr (mod 4).
- The first requester in that order with req[i]=1 is the winner.
- ack:
  - ack[winner]=1 when en=1 and req!=0; all other ack bits are 0.
  - ack=0 when en=0, req=0, or reset=1.
- At a rising edge with a winner present:
  - q <= data slice of winner
  - owner <= winner
  - valid <= 1
  - ptr <= winner
- No winner: q, owner, valid and ptr hold their values.
- Handshake:
  - A requester holds req[i] and its data stable until it samples ack[i]=1 at a rising edge. That edge is the write edge.
  - The requester then deasserts req[i] or presents new data for another write.
  - Holding req[i] high after ack is a new request. It competes at lowest priority, because ptr=i.
- A requester that is the only one requesting wins every cycle (back-to-back writes allowed).
- Combinational ack path: req/en to ack only, with no path from q. No combinational loop through the register.
- The register stage has the same semantics as the team's enabled D flip-flop: load on edge when enabled, otherwise hold. Enable = any ack bit.

## Timing
- Grant latency: 0 cycles. ack is valid in the same cycle req is asserted.
- Write latency: q, owner and valid update at the rising edge that ends the ack cycle. They are visible 1 cycle after req is first seen (uncontended case).
- Worst-case wait with all 4 requesting continuously: 3 cycles between a request becoming eligible and its grant. Each requester gets exactly one grant per 4 cycles.
- Simultaneous requests resolve strictly by the rotating order. Ties are impossible.
- en deasserted mid-sequence: no grant and no state change. ptr holds, so rotation resumes where it stopped.
- Reset asserted mid-operation:
  - All outputs clear immediately, without waiting for an edge.
  - ack drops in the same cycle.
  - A write pending at that edge is discarded.
- Reset deassertion: the first edge with reset=0 may perform a write, with requester 0 at highest priority.
- Unused request lines (req[i] tied 0) are simply skipped. The pointer never lands on them.

## Test plan
- Reset, then req=4'b0000 for 3 cycles:
  - required: q=0x00, owner=0, valid=0, ack=0000 throughout.
- Single request: req=0100 with data slice 2=0xA5 for 1 cycle.
  - required: ack=0100 that cycle.
  - required after the edge: q=0xA5, owner=2, valid=1; q holds once req drops.
- All four requesting continuously from reset, with data slices 0x10, 0x21, 0x32, 0x43:
  - required: ack sequence 0001, 0010, 0100, 1000, 0001.
  - required: q sequence 0x10, 0x21, 0x32, 0x43, 0x10.
- Rotation fairness: after owner=1, present req=0011.
  - required: ack=0001 (requester 0 wins, since 1 was last winner).
  - required: on the next cycle with req=0011, ack=0010.
- en=0 with req=1111 for 2 cycles, then en=1:
  - required: no change in q/owner/ptr while en=0.
  - required: first grant goes to ptr+1.
- Assert reset for 1 cycle while req=1111 and q=0x43:
  - required: q=0x00, valid=0, ack=0000 immediately.
  - required: after release, the first ack=0001.
